// File: rtl/phys_free_list.sv
// Circular free list of physical register indices for rename/dispatch.
// Optional FREE_LIST_P0_FILTER_EN: enqueues of p0 are dropped.
module phys_free_list #(
   parameter int ROB_DEPTH = 32,
   parameter int PW        = $clog2(ROB_DEPTH + 32),
   parameter int PTRW      = $clog2(ROB_DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fl_deq,
   output logic [PW-1:0]   fl_p_addr,
   output logic            fl_empty,
   output logic [PTRW-1:0] fl_count,
   output logic [PTRW-1:0] fl_head,
   input  logic            fl_enq0,
   input  logic            fl_enq1,
   input  logic [PW-1:0]   fl_enq_p_addr0,
   input  logic [PW-1:0]   fl_enq_p_addr1,
   input  logic            flush,
   input  logic [PTRW-1:0] flush_head
);

   localparam logic [PTRW-1:0] DEPTH = PTRW'(ROB_DEPTH);

   logic [PW-1:0]   r_mem [ROB_DEPTH];
   logic [PTRW-1:0] r_head;
   logic [PTRW-1:0] r_tail;

   logic [PTRW-1:0] w_count;
   logic [PTRW-1:0] w_cnt0;
   logic [PTRW-1:0] w_tail1;
   logic            w_empty;
   logic            w_v0;
   logic            w_v1;
   logic            w_acc0;
   logic            w_acc1;
   logic            w_drop;

   assign w_count = r_tail - r_head;
   assign w_empty = (w_count == '0);

`ifdef FREE_LIST_P0_FILTER_EN
   assign w_v0 = fl_enq0 && (fl_enq_p_addr0 != '0);
   assign w_v1 = fl_enq1 && (fl_enq_p_addr1 != '0);
`else
   assign w_v0 = fl_enq0;
   assign w_v1 = fl_enq1;
`endif

   // Capacity is judged on start-of-cycle occupancy; a same-cycle
   // dequeue does not make room.
   assign w_acc0  = w_v0 && (w_count < DEPTH);
   assign w_cnt0  = w_count + PTRW'(w_acc0);
   assign w_acc1  = w_v1 && (w_cnt0 < DEPTH);
   assign w_tail1 = r_tail + PTRW'(w_acc0);
   assign w_drop  = (w_v0 && !w_acc0) || (w_v1 && !w_acc1);

   assign fl_p_addr = r_mem[r_head[PTRW-2:0]];
   assign fl_empty  = w_empty;
   assign fl_count  = w_count;
   assign fl_head   = r_head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            r_mem[i] <= PW'(32 + i);
         end
         r_head <= '0;
         r_tail <= DEPTH;
      end else begin
         if (w_acc0) begin
            r_mem[r_tail[PTRW-2:0]] <= fl_enq_p_addr0;
         end
         if (w_acc1) begin
            r_mem[w_tail1[PTRW-2:0]] <= fl_enq_p_addr1;
         end
         r_tail <= w_tail1 + PTRW'(w_acc1);
         // Restoring head alone revives squashed allocations in place.
         if (flush) begin
            r_head <= flush_head;
         end else if (fl_deq && !w_empty) begin
            r_head <= r_head + 1'b1;
         end
      end
   end

   a_no_overflow : assert property (
      @(posedge clk) disable iff (rst) !w_drop
   );

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list with a per-cycle reference model.
// Expected p0 behaviour follows FREE_LIST_P0_FILTER_EN.
module tb_phys_free_list;

   localparam int D    = 32;
   localparam int PW   = 6;
   localparam int PTRW = 6;
   localparam int PMOD = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            fl_deq;
   logic [PW-1:0]   fl_p_addr;
   logic            fl_empty;
   logic [PTRW-1:0] fl_count;
   logic [PTRW-1:0] fl_head;
   logic            fl_enq0;
   logic            fl_enq1;
   logic [PW-1:0]   fl_enq_p_addr0;
   logic [PW-1:0]   fl_enq_p_addr1;
   logic            flush;
   logic [PTRW-1:0] flush_head;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   phys_free_list #(.ROB_DEPTH(D)) dut (
      .clk            (clk),
      .rst            (rst),
      .fl_deq         (fl_deq),
      .fl_p_addr      (fl_p_addr),
      .fl_empty       (fl_empty),
      .fl_count       (fl_count),
      .fl_head        (fl_head),
      .fl_enq0        (fl_enq0),
      .fl_enq1        (fl_enq1),
      .fl_enq_p_addr0 (fl_enq_p_addr0),
      .fl_enq_p_addr1 (fl_enq_p_addr1),
      .flush          (flush),
      .flush_head     (flush_head)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", n, act, exp);
      end
   endtask

   // Reference model: slot contents plus free-running pointers mod 64.
   int m_mem [D];
   int m_head;
   int m_tail;
   int mc;
   int ma0;
   int ma1;

   function automatic int lane_ok(input logic e, input logic [PW-1:0] a);
`ifdef FREE_LIST_P0_FILTER_EN
      return (e && a != 0) ? 1 : 0;
`else
      return e ? 1 : 0;
`endif
   endfunction

   always_comb begin
      mc  = (m_tail - m_head + PMOD) % PMOD;
      ma0 = (lane_ok(fl_enq0, fl_enq_p_addr0) == 1 && mc < D) ? 1 : 0;
      ma1 = (lane_ok(fl_enq1, fl_enq_p_addr1) == 1 && mc + ma0 < D)
            ? 1 : 0;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < D; i++) m_mem[i] <= 32 + i;
         m_head <= 0;
         m_tail <= D;
      end else begin
         if (ma0 == 1) m_mem[m_tail % D] <= int'(fl_enq_p_addr0);
         if (ma1 == 1) m_mem[(m_tail + ma0) % D] <= int'(fl_enq_p_addr1);
         m_tail <= (m_tail + ma0 + ma1) % PMOD;
         if (flush) m_head <= int'(flush_head);
         else if (fl_deq && mc != 0) m_head <= (m_head + 1) % PMOD;
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("m_count", int'(fl_count), mc);
         chk("m_head", int'(fl_head), m_head);
         chk("m_empty", int'(fl_empty), (mc == 0) ? 1 : 0);
         if (mc != 0) chk("m_paddr", int'(fl_p_addr), m_mem[m_head % D]);
      end
   end

   task automatic cyc(input bit d, input bit e0, input int a0,
                      input bit e1, input int a1,
                      input bit f, input int fh);
      fl_deq         = d;
      fl_enq0        = e0;
      fl_enq_p_addr0 = PW'(a0);
      fl_enq1        = e1;
      fl_enq_p_addr1 = PW'(a1);
      flush          = f;
      flush_head     = PTRW'(fh);
      @(posedge clk);
      #2;
      fl_deq  = 1'b0;
      fl_enq0 = 1'b0;
      fl_enq1 = 1'b0;
      flush   = 1'b0;
   endtask

   task automatic deq();
      cyc(1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b0;
      fl_deq = 1'b0;
      fl_enq0 = 1'b0;
      fl_enq1 = 1'b0;
      fl_enq_p_addr0 = '0;
      fl_enq_p_addr1 = '0;
      flush = 1'b0;
      flush_head = '0;
      #1 rst = 1'b1;
      #3 rst = 1'b0;
      chk_en = 1'b1;

      chk("rst_count", int'(fl_count), 32);
      chk("rst_paddr", int'(fl_p_addr), 32);
      chk("rst_empty", int'(fl_empty), 0);
      chk("rst_head", int'(fl_head), 0);

      for (int i = 0; i < 32; i++) begin
         chk("drain_paddr", int'(fl_p_addr), 32 + i);
         deq();
      end
      chk("drain_empty", int'(fl_empty), 1);
      chk("drain_count", int'(fl_count), 0);

      cyc(0, 1, 40, 1, 45, 0, 0);
      chk("enq2_count", int'(fl_count), 2);
      chk("enq2_paddr", int'(fl_p_addr), 40);
      deq();
      chk("enq2_next", int'(fl_p_addr), 45);
      deq();
      chk("enq2_empty", int'(fl_empty), 1);

      chk("eod_head_pre", int'(fl_head), 34);
      chk("eod_empty_pre", int'(fl_empty), 1);
      cyc(1, 1, 33, 0, 0, 0, 0);
      chk("eod_head", int'(fl_head), 34);
      chk("eod_paddr", int'(fl_p_addr), 33);
      chk("eod_count", int'(fl_count), 1);
      deq();

      rst = 1'b1;
      #1;
      chk("arst_count", int'(fl_count), 32);
      chk("arst_paddr", int'(fl_p_addr), 32);
      chk("arst_head", int'(fl_head), 0);
      chk("arst_empty", int'(fl_empty), 0);
      rst = 1'b0;
      #1;

      chk("ckpt_head", int'(fl_head), 0);
      repeat (5) deq();
      chk("pre_fl_paddr", int'(fl_p_addr), 37);
      chk("pre_fl_count", int'(fl_count), 27);
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("fl0_count", int'(fl_count), 32);
      chk("fl0_paddr", int'(fl_p_addr), 32);
      chk("fl0_head", int'(fl_head), 0);

      repeat (2) deq();
      chk("fl2_pre_count", int'(fl_count), 30);
      cyc(1, 1, 50, 0, 0, 1, 2);
      chk("fl2_head", int'(fl_head), 2);
      chk("fl2_count", int'(fl_count), 31);
      chk("fl2_paddr", int'(fl_p_addr), 34);
      repeat (30) deq();
      chk("fl2_p50", int'(fl_p_addr), 50);
      chk("fl2_tail_cnt", int'(fl_count), 1);
      deq();

      cyc(0, 1, 0, 1, 7, 0, 0);
`ifdef FREE_LIST_P0_FILTER_EN
      chk("p0_count", int'(fl_count), 1);
      chk("p0_paddr", int'(fl_p_addr), 7);
`else
      chk("p0_count", int'(fl_count), 2);
      chk("p0_paddr", int'(fl_p_addr), 0);
      deq();
      chk("p0_next", int'(fl_p_addr), 7);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phys_free_list.md
# phys_free_list

Circular FIFO of free physical register indices feeding the rename/dispatch stage. Each cycle it supplies the next free physical index that dispatch writes into the RAT as the new mapping for `rd`. It reclaims up to two freed indices per cycle from commit. On a branch mispredict it restores its head pointer from a checkpoint taken at dispatch, alongside the RAT checkpoint.

## Interface
- `ROB_DEPTH`, 32: number of free-list entries. Power of two, ≥ 4.
- `PW`, `$clog2(ROB_DEPTH+32)`: physical index width, matching the RAT `p_addr` width.
- `PTRW`, `$clog2(ROB_DEPTH)+1`: pointer width, including one wrap bit.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fl_deq` in 1: dispatch consumes `fl_p_addr` this cycle.
- `fl_p_addr` out PW: next free physical index, equal to `mem[head]`. Combinational.
- `fl_empty` out 1: no free entry. When high, `fl_p_addr` is don't-care.
- `fl_count` out PTRW: number of free entries held, 0..ROB_DEPTH.
- `fl_head` out PTRW: current head pointer. Dispatch snapshots it with each branch.
- `fl_enq0`, `fl_enq1` in 1: commit frees an index on lane 0 / lane 1.
- `fl_enq_p_addr0`, `fl_enq_p_addr1` in PW: the freed indices.
- `flush` in 1: mispredict restore (driven from `br_mispred & cdb_broadcast`).
- `flush_head` in PTRW: head checkpoint of the mispredicted branch.

## Operation
- Storage: `mem[ROB_DEPTH]` of PW bits, with pointers `head` and `tail`, each PTRW bits.
  - Slot index is `ptr[PTRW-2:0]`; the top bit is the wrap bit.
  - `fl_count = tail - head` (modulo 2^PTRW). `fl_empty = (fl_count == 0)`.
- Reset: `mem[i] = 32 + i`, `head = 0`, `tail = ROB_DEPTH` (wrap bit set, full). p1..p31 are never in circulation.
- Dequeue: when `fl_deq & !fl_empty & !flush`, `head <= head + 1`. `fl_deq` while empty is ignored and `head` holds.
- Enqueue:
  - Accepted lanes are written in order: lane 0 at `tail`, lane 1 at `tail + (lane 0 accepted)`.
  - `tail` advances by the number of accepted lanes (0, 1 or 2).
  - Enqueue is accepted during `flush`. Freed indices come from committed instructions, which are older than the branch.
  - A lane that would exceed ROB_DEPTH entries is dropped. This is a simulation-assertion error.
- Flush: `head <= flush_head`. `tail` follows the enqueue rules above.
  - Slots between `flush_head` and the old `head` are not overwritten, so the indices allocated to squashed instructions become free again with no copy.
  - `fl_deq` is ignored in a flush cycle.
- Simultaneous dequeue and enqueue: both apply, with no bypass. If empty at the start of the cycle, `fl_empty` stays high and the enqueued index is visible next cycle.

## Timing
- `fl_p_addr`, `fl_empty`, `fl_count` and `fl_head` are combinational from registered state. Zero-latency read of the head entry.
- After dequeue, the next index is visible in the following cycle.
- An enqueued index is dequeueable at the earliest one cycle after its enqueue edge.
- Flush takes effect at the edge. The following cycle shows the restored `fl_head` and `fl_count`.
- Reset values of outputs: `fl_p_addr = 32`, `fl_empty = 0`, `fl_count = ROB_DEPTH`, `fl_head = 0`.
- Asserting `rst` mid-operation discards all in-flight state immediately, independent of `clk`.

## Configuration
- `FREE_LIST_P0_FILTER_EN` defined:
  - Any enqueue lane whose `fl_enq_p_addr == 0` is treated as not asserted.
  - Reason: architectural registers reset-map to p0, so freeing that mapping must never put p0 in the list.
- Not defined: p0 enqueues are accepted like any other index. Commit must then filter them itself.

## Test plan
- Reset with ROB_DEPTH=32 → `fl_count = 32`, `fl_p_addr = 32`, `fl_empty = 0`. 32 consecutive `fl_deq` yield 32..63, then `fl_empty = 1` and `fl_count = 0`.
- From empty, enqueue p40 on lane 0 and p45 on lane 1 in one cycle → next cycle `fl_count = 2`, `fl_p_addr = 40`. Dequeue → `fl_p_addr = 45`.
- From reset, capture `fl_head = 0`, dequeue 5 (32..36), then `flush` with `flush_head = 0` → `fl_count = 32`, `fl_p_addr = 32`.
- `flush` with `flush_head = 2`, same-cycle `fl_deq` and `fl_enq0 = p50` while the list holds 30 → `fl_deq` ignored; p50 written at `tail`; `fl_count = tail_new - 2`.
- `fl_deq` on empty with same-cycle enqueue of p33 → `head` unchanged, `fl_empty = 1` that cycle. Next cycle `fl_p_addr = 33`, `fl_count = 1`.
- With `FREE_LIST_P0_FILTER_EN`, enqueue p0 on lane 0 and p7 on lane 1 → only p7 is written, `fl_count` rises by 1. Without the macro, both are written and `fl_count` rises by 2.
